// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default widths for the memory port arbiter
package mem_arb_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDRESS_BITS = 12;
  localparam int DEF_MAX_WAIT = 4;
  localparam int WAIT_BITS = 4;
  typedef enum logic {ST_PROGRAM, ST_RUN} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_e;
endpackage

// File: rtl/arb_wait_counter.sv
// arb_wait_counter: saturating count of consecutive denied fetch cycles
module arb_wait_counter
  import mem_arb_pkg::*;
(
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_inc,
  input  logic                 i_clr,
  input  logic [WAIT_BITS-1:0] i_limit,
  output logic                 o_at_limit
);
  logic [WAIT_BITS-1:0] r_cnt;
  always_ff @(posedge i_clock)
    if (!i_reset || i_clr) r_cnt <= '0;
    else if (i_inc && r_cnt < i_limit) r_cnt <= r_cnt + 1'b1;
  assign o_at_limit = r_cnt == i_limit;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between ISP, core data and core fetch
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDRESS_BITS = DEF_ADDRESS_BITS,
  parameter int MAX_WAIT     = DEF_MAX_WAIT
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic [ADDRESS_BITS-1:0] i_isp_address,
  input  logic [DATA_WIDTH-1:0]   i_isp_data,
  input  logic                    i_isp_write,
  input  logic                    i_if_req,
  input  logic [ADDRESS_BITS-1:0] i_if_addr,
  output logic                    o_if_grant,
  output logic                    o_if_rvalid,
  output logic [DATA_WIDTH-1:0]   o_if_rdata,
  input  logic                    i_d_req,
  input  logic                    i_d_we,
  input  logic [ADDRESS_BITS-1:0] i_d_addr,
  input  logic [DATA_WIDTH-1:0]   i_d_wdata,
  output logic                    o_d_grant,
  output logic                    o_d_rvalid,
  output logic [DATA_WIDTH-1:0]   o_d_rdata,
  output logic                    o_mem_en,
  output logic                    o_mem_we,
  output logic [ADDRESS_BITS-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
  output logic                    o_core_stall,
  output logic [31:0]             o_conflict_count
);
  state_e      r_state;
  owner_e      r_owner;
  logic [31:0] r_conflict;
  logic        w_run, w_at_limit, w_if_win, w_d_win;
  assign w_run = r_state == ST_RUN;
  // A starved fetch jumps ahead of data; the ISP always wins outright
  assign w_if_win = w_run && !i_isp_write && i_if_req && (w_at_limit || !i_d_req);
  assign w_d_win = w_run && !i_isp_write && i_d_req && !(i_if_req && w_at_limit);
  always_comb begin
    o_mem_en = i_isp_write || w_if_win || w_d_win;
    o_mem_we = i_isp_write || (w_d_win && i_d_we);
    o_mem_addr = i_isp_write ? i_isp_address : w_if_win ? i_if_addr : w_d_win ? i_d_addr : '0;
    o_mem_wdata = i_isp_write ? i_isp_data : w_d_win ? i_d_wdata : '0;
  end
  assign o_if_grant = w_if_win;
  assign o_d_grant = w_d_win;
  assign o_if_rvalid = r_owner == OWN_IF;
  assign o_d_rvalid = r_owner == OWN_D;
  assign o_if_rdata = i_mem_rdata;
  assign o_d_rdata = i_mem_rdata;
  assign o_core_stall = !w_run || (i_if_req && !w_if_win) || (i_d_req && !w_d_win);
  assign o_conflict_count = r_conflict;
  always_ff @(posedge i_clock)
    if (!i_reset) begin
      r_state <= ST_PROGRAM;
      r_owner <= OWN_NONE;
      r_conflict <= '0;
    end else begin
      if (r_state == ST_PROGRAM && i_start) r_state <= ST_RUN;
      r_owner <= w_if_win ? OWN_IF : (w_d_win && !i_d_we) ? OWN_D : OWN_NONE;
      if (w_run && i_if_req && i_d_req) r_conflict <= r_conflict + 32'd1;
    end
  arb_wait_counter u_wait (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_inc(w_run && i_if_req && !w_if_win),
    .i_clr(w_if_win || !i_if_req),
    .i_limit(WAIT_BITS'(MAX_WAIT)),
    .o_at_limit(w_at_limit)
  );
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks against a behavioural model
module tb_mem_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 12;
  localparam int MW = 4;
  logic clk = 0, rst_n = 0, start = 0, isp_write = 0, if_req = 0, d_req = 0, d_we = 0;
  logic [AW-1:0] isp_address = '0, if_addr = '0, d_addr = '0;
  logic [DW-1:0] isp_data = '0, d_wdata = '0, mem_rdata;
  logic if_grant, if_rvalid, d_grant, d_rvalid, mem_en, mem_we, core_stall;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [31:0] conflict_count;
  logic [DW-1:0] env_mem [4096];
  logic [DW-1:0] ref_mem [4096];
  bit m_run;
  int m_wait, m_pend;
  logic [DW-1:0] m_pdata;
  logic [31:0] m_conf;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDRESS_BITS(AW), .MAX_WAIT(MW)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_start(start),
    .i_isp_address(isp_address), .i_isp_data(isp_data), .i_isp_write(isp_write),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_grant(if_grant),
    .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_grant(d_grant), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .o_core_stall(core_stall), .o_conflict_count(conflict_count)
  );
  always @(posedge clk) begin
    if (mem_en && mem_we) env_mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= env_mem[mem_addr];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cycle();
    int w;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic ewe;
    #1;
    w = isp_write ? 1 : !m_run ? 0 : (if_req && m_wait == MW) ? 2 : d_req ? 3 : if_req ? 2 : 0;
    ea = w == 1 ? isp_address : w == 2 ? if_addr : w == 3 ? d_addr : '0;
    ed = w == 1 ? isp_data : w == 3 ? d_wdata : '0;
    ewe = w == 1 || (w == 3 && d_we);
    chk("if_grant", if_grant, w == 2);
    chk("d_grant", d_grant, w == 3);
    chk("mem_en", mem_en, w != 0);
    chk("mem_we", mem_we, ewe);
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ed);
    chk("core_stall", core_stall, !m_run || (if_req && w != 2) || (d_req && w != 3));
    @(posedge clk);
    if (!rst_n) begin
      m_run = 0; m_wait = 0; m_pend = 0; m_conf = 0;
    end else begin
      m_pend = w == 2 ? 1 : (w == 3 && !d_we) ? 2 : 0;
      if (m_pend != 0) m_pdata = ref_mem[ea];
      if (m_run && if_req && d_req) m_conf++;
      m_wait = (!if_req || w == 2) ? 0 : m_run ? (m_wait < MW ? m_wait + 1 : MW) : m_wait;
      if (start) m_run = 1;
    end
    if (ewe) ref_mem[ea] = ed;
    #1;
    chk("if_rvalid", if_rvalid, m_pend == 1);
    chk("d_rvalid", d_rvalid, m_pend == 2);
    if (m_pend == 1) chk("if_rdata", if_rdata, m_pdata);
    if (m_pend == 2) chk("d_rdata", d_rdata, m_pdata);
    chk("conflict_count", conflict_count, m_conf);
  endtask
  initial begin
    m_run = 0; m_wait = 0; m_pend = 0; m_conf = 0; m_pdata = '0;
    repeat (2) cycle();
    rst_n = 1;
    for (int i = 0; i < 16; i++) begin
      isp_write = 1; isp_address = AW'(i); isp_data = $urandom; cycle();
    end
    isp_address = 12'h010; isp_data = 32'hDEADBEEF; cycle();
    isp_address = 12'h020; isp_data = 32'h12345678; start = 1; cycle();
    isp_write = 0; start = 0;
    if_req = 1; if_addr = 12'h010; cycle();
    chk("boot_fetch_data", if_rdata, 32'hDEADBEEF);
    d_req = 1; d_we = 0; d_addr = 12'h020; cycle();
    chk("conflict_read_data", d_rdata, 32'h12345678);
    chk("first_conflict", conflict_count, 32'd1);
    if_req = 0; d_req = 0; cycle();
    if_req = 1; d_req = 1; if_addr = 12'h003; d_addr = 12'h004;
    repeat (4) cycle();
    #1 chk("starved_fetch_grant", if_grant, 1'b1);
    repeat (3) cycle();
    isp_write = 1; isp_address = 12'h005; isp_data = $urandom;
    d_we = 1; d_addr = 12'h003; d_wdata = $urandom; cycle();
    isp_write = 0; cycle();
    d_req = 0; d_we = 0; if_req = 1; if_addr = 12'h007; cycle();
    rst_n = 0; cycle();
    rst_n = 1; if_req = 0; cycle();
    if_req = 1; d_req = 1;
    for (int i = 0; i < 10; i++) begin
      isp_write = i % 3 == 0; isp_address = AW'($urandom_range(0, 15)); isp_data = $urandom; cycle();
    end
    chk("program_no_conflict", conflict_count, 32'd0);
    isp_write = 0; if_req = 0; d_req = 0; start = 1; cycle();
    start = 0;
    for (int i = 0; i < 500; i++) begin
      rst_n = $urandom_range(0, 79) != 0;
      start = $urandom_range(0, 19) == 0;
      isp_write = $urandom_range(0, 9) == 0;
      isp_address = AW'($urandom_range(0, 15)); isp_data = $urandom;
      if_req = $urandom_range(0, 2) != 0; if_addr = AW'($urandom_range(0, 15));
      d_req = $urandom_range(0, 1) != 0; d_we = $urandom_range(0, 2) == 0;
      d_addr = AW'($urandom_range(0, 15)); d_wdata = $urandom;
      cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
